// File: rtl/arb_rr_sched_if.sv
// Grant handshake between the round-robin scheduler and the 8b10b encoder.
// The scheduler drives the master modport, the encoder the slave modport.
interface arb_rr_sched_if #(
  parameter int IDW = 2
);
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           grant_ready;

  modport master (output grant_valid, output grant_id, input grant_ready);
  modport slave  (input grant_valid, input grant_id, output grant_ready);
endinterface

// File: rtl/arb_rr_sched.sv
// Round-robin packet scheduler: per-port saturating pending counters feeding a grant handshake.
// Optional macro ARB_BACK2BACK_EN removes the idle bubble after each accepted grant.
module arb_rr_sched #(
  parameter int NPORTS = 4,
  parameter int NBITS  = 4,
  parameter int IDW    = $clog2(NPORTS)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NPORTS-1:0]       req_en,
  input  logic [NPORTS-1:0]       clear,
  arb_rr_sched_if.master          gnt,
  output logic [NPORTS*NBITS-1:0] pending_cnt,
  output logic [NPORTS-1:0]       ovf,
  output logic                    busy
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [NBITS-1:0] CNT_MAX = '1;

  state_t           state;
  logic [NBITS-1:0] cnt [NPORTS];
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id_q;
  logic             grant_valid_q;

  logic              accept;
  logic              withdraw;
  logic              take;
  logic [IDW-1:0]    ptr_adv;
  logic [NPORTS-1:0] dec;
  logic [NPORTS-1:0] nz_idle;
  logic [IDW:0]      pick_idle;

  // First set bit of nz at or after start, wrapping; MSB of the result flags a hit.
  function automatic logic [IDW:0] rr_pick(input logic [NPORTS-1:0] nz,
                                           input logic [IDW-1:0]    start);
    logic [IDW:0] r;
    int           idx;
    r = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (nz[idx]) r = {1'b1, IDW'(idx)};
    end
    return r;
  endfunction

  assign accept   = grant_valid_q && gnt.grant_ready;
  assign withdraw = grant_valid_q && clear[grant_id_q];
  assign take     = accept && !withdraw;
  assign ptr_adv  = (grant_id_q == IDW'(NPORTS - 1)) ? '0 : grant_id_q + IDW'(1);

  // A port being cleared on this edge must not be picked: its count is about to vanish.
  always_comb begin
    dec     = '0;
    nz_idle = '0;
    for (int i = 0; i < NPORTS; i++) begin
      dec[i]     = take && (grant_id_q == IDW'(i));
      nz_idle[i] = (cnt[i] != '0) && !clear[i];
    end
  end

  assign pick_idle = rr_pick(nz_idle, rr_ptr);

`ifdef ARB_BACK2BACK_EN
  logic [NPORTS-1:0] nz_post;
  logic [IDW:0]      pick_post;

  // Post-accept view excludes this edge's increments so request-to-grant latency is unchanged.
  always_comb begin
    nz_post = '0;
    for (int i = 0; i < NPORTS; i++) begin
      nz_post[i] = (cnt[i] > NBITS'(dec[i])) && !clear[i];
    end
  end

  assign pick_post = rr_pick(nz_post, ptr_adv);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NPORTS; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (clear[i]) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (req_en[i] && dec[i]) begin
          cnt[i] <= cnt[i];
        end else if (req_en[i]) begin
          if (cnt[i] == CNT_MAX) ovf[i] <= 1'b1;
          else                   cnt[i] <= cnt[i] + NBITS'(1);
        end else if (dec[i]) begin
          cnt[i] <= cnt[i] - NBITS'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[IDW]) begin
            state         <= GRANT;
            grant_valid_q <= 1'b1;
            grant_id_q    <= pick_idle[IDW-1:0];
          end
        end
        GRANT: begin
          if (withdraw) begin
            state         <= IDLE;
            grant_valid_q <= 1'b0;
          end else if (accept) begin
            rr_ptr <= ptr_adv;
`ifdef ARB_BACK2BACK_EN
            if (pick_post[IDW]) begin
              grant_id_q <= pick_post[IDW-1:0];
            end else begin
              state         <= IDLE;
              grant_valid_q <= 1'b0;
            end
`else
            state         <= IDLE;
            grant_valid_q <= 1'b0;
`endif
          end
        end
        default: begin
          state         <= IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_flat
    assign pending_cnt[g*NBITS +: NBITS] = cnt[g];
  end

  assign gnt.grant_valid = grant_valid_q;
  assign gnt.grant_id    = grant_id_q;
  assign busy            = grant_valid_q || (|pending_cnt);
endmodule

// File: tb/tb_arb_rr_sched.sv
// Bench for arb_rr_sched: directed scenarios plus random traffic against a queue-based reference model.
// Expected grants are queued by the model and popped by an independent monitor.
module tb_arb_rr_sched;
  localparam int NP   = 4;
  localparam int NB   = 4;
  localparam int IW   = 2;
  localparam int CMAX = (1 << NB) - 1;
`ifdef ARB_BACK2BACK_EN
  localparam int EXP_GAPS = 0;
`else
  localparam int EXP_GAPS = 5;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic [NP-1:0]    req_en;
  logic [NP-1:0]    clear;
  logic [NP*NB-1:0] pending_cnt;
  logic [NP-1:0]    ovf;
  logic             busy;

  arb_rr_sched_if #(.IDW(IW)) gnt_if ();

  arb_rr_sched #(.NPORTS(NP), .NBITS(NB), .IDW(IW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_en      (req_en),
    .clear       (clear),
    .gnt         (gnt_if),
    .pending_cnt (pending_cnt),
    .ovf         (ovf),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model state: plain integer counts, a pointer and the port currently granted (-1 = none).
  int        m_cnt [NP];
  bit [NP-1:0] m_ovf = '0;
  int        m_ptr = 0;
  int        m_cur = -1;
  int        exp_q[$];
  int        acc_log[$];
  bit        mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int p);
    return int'(pending_cnt[p*NB +: NB]);
  endfunction

  function automatic int rr_first(input int start, input int base[NP], input bit [NP-1:0] clr);
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (start + k) % NP;
      if (base[p] > 0 && !clr[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_update();
    int old[NP];
    int acc;
    bit wd;
    acc = -1;
    wd  = 1'b0;
    old = m_cnt;
    if (RST) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ovf = '0;
      m_ptr = 0;
      m_cur = -1;
      return;
    end
    if (m_cur >= 0) begin
      if (clear[m_cur]) wd = 1'b1;
      else if (gnt_if.grant_ready) acc = m_cur;
    end
    for (int i = 0; i < NP; i++) begin
      if (clear[i]) begin
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end else if (req_en[i] && i != acc) begin
        if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
        else                  m_cnt[i] = m_cnt[i] + 1;
      end else if (!req_en[i] && i == acc) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
    if (m_cur < 0) begin
      m_cur = rr_first(m_ptr, old, clear);
      if (m_cur >= 0) exp_q.push_back(m_cur);
    end else if (wd) begin
      m_cur = -1;
    end else if (acc >= 0) begin
      m_ptr = (acc + 1) % NP;
`ifdef ARB_BACK2BACK_EN
      old[acc] = old[acc] - 1;
      m_cur = rr_first(m_ptr, old, clear);
      if (m_cur >= 0) exp_q.push_back(m_cur);
`else
      m_cur = -1;
`endif
    end
  endtask

  task automatic drive(input logic [NP-1:0] r, input logic [NP-1:0] c, input logic rdy, input logic rst);
    req_en             = r;
    clear              = c;
    gnt_if.grant_ready = rdy;
    RST                = rst;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic step(input logic [NP-1:0] r, input logic [NP-1:0] c, input logic rdy);
    drive(r, c, rdy, 1'b0);
    tick();
  endtask

  // Idles until a grant is presented, bounded; returns -1 on timeout.
  task automatic wait_grant(output int id);
    id = -1;
    drive('0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 8 && id < 0; k++) begin
      if (gnt_if.grant_valid) id = int'(gnt_if.grant_id);
      else tick();
    end
    if (id < 0) chk("wait_grant_timeout", 0, 1);
  endtask

  // Monitor: per-cycle state comparison plus scoreboard pop on every newly presented grant.
  initial begin
    logic [NP*NB-1:0] ev;
    bit last_v;
    bit last_done;
    last_v    = 1'b0;
    last_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        for (int i = 0; i < NP; i++) ev[i*NB +: NB] = NB'(m_cnt[i]);
        chk("pending_cnt", int'(pending_cnt), int'(ev));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("grant_valid", int'(gnt_if.grant_valid), int'(m_cur >= 0));
        chk("busy", int'(busy), int'(m_cur >= 0 || ev != '0));
        if (gnt_if.grant_valid && (!last_v || last_done)) begin
          if (exp_q.size() == 0) chk("grant_unexpected", int'(gnt_if.grant_id), -1);
          else chk("grant_id", int'(gnt_if.grant_id), exp_q.pop_front());
        end
        if (gnt_if.grant_valid && gnt_if.grant_ready) acc_log.push_back(int'(gnt_if.grant_id));
        last_v    = gnt_if.grant_valid;
        last_done = RST || (gnt_if.grant_valid && (gnt_if.grant_ready || clear[gnt_if.grant_id]));
      end
    end
  end

  initial begin
    int id;
    int gaps;
    int presented;
    int exp_f[6];
    exp_f = '{0, 1, 3, 0, 1, 3};
    foreach (m_cnt[i]) m_cnt[i] = 0;

    // Reset and counting
    drive('0, '0, 1'b0, 1'b1);
    tick();
    tick();
    chk("rst_valid", int'(gnt_if.grant_valid), 0);
    chk("rst_id", int'(gnt_if.grant_id), 0);
    chk("rst_cnt", int'(pending_cnt), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    mon_en = 1'b1;
    step(4'b0001, '0, 1'b0);
    chk("req1_valid", int'(gnt_if.grant_valid), 0);
    step(4'b0001, '0, 1'b0);
    step(4'b0001, '0, 1'b0);
    chk("req_cnt0", cnt_of(0), 3);
    chk("req_valid", int'(gnt_if.grant_valid), 1);
    chk("req_id", int'(gnt_if.grant_id), 0);
    chk("req_busy", int'(busy), 1);
    step('0, 4'b0001, 1'b0);
    chk("clr0_valid", int'(gnt_if.grant_valid), 0);
    chk("clr0_cnt", cnt_of(0), 0);

    // Round-robin fairness over ports 0, 1, 3
    step(4'b1011, '0, 1'b0);
    step(4'b1011, '0, 1'b0);
    acc_log.delete();
    gaps      = 0;
    presented = 0;
    for (int k = 0; k < 14; k++) begin
      if (gnt_if.grant_valid) presented++;
      else if (presented > 0 && presented < 6) gaps++;
      step('0, '0, 1'b1);
    end
    chk("fair_n", acc_log.size(), 6);
    for (int k = 0; k < 6; k++) if (k < acc_log.size()) chk("fair_id", acc_log[k], exp_f[k]);
    chk("fair_gaps", gaps, EXP_GAPS);
    chk("fair_cnt", int'(pending_cnt), 0);

    // Saturation and sticky overflow on port 2
    for (int k = 0; k < 17; k++) step(4'b0100, '0, 1'b0);
    chk("sat_cnt2", cnt_of(2), 15);
    chk("sat_ovf2", int'(ovf[2]), 1);
    step('0, 4'b0100, 1'b0);
    chk("satclr_cnt2", cnt_of(2), 0);
    chk("satclr_ovf2", int'(ovf[2]), 0);

    // Simultaneous increment and accept on port 1; next grant proves pointer moved to 2
    step(4'b0010, '0, 1'b0);
    step(4'b0010, '0, 1'b0);
    chk("incdec_id", int'(gnt_if.grant_id), 1);
    step(4'b1010, '0, 1'b0);
    step(4'b0010, '0, 1'b1);
    chk("incdec_cnt1", cnt_of(1), 3);
    wait_grant(id);
    chk("incdec_ptr", id, 3);
    step('0, 4'b1111, 1'b0);

    // Stall on port 0, then withdraw via clear
    step(4'b0011, '0, 1'b0);
    step('0, '0, 1'b0);
    step(4'b1000, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", int'(gnt_if.grant_valid), 1);
      chk("stall_id", int'(gnt_if.grant_id), 0);
      step('0, '0, 1'b0);
    end
    step('0, 4'b0001, 1'b1);
    chk("wd_valid", int'(gnt_if.grant_valid), 0);
    chk("wd_cnt1", cnt_of(1), 1);
    chk("wd_cnt3", cnt_of(3), 1);
    wait_grant(id);
    chk("wd_ptr", id, 3);

    // Reset mid-grant: nothing moves before the edge
    drive('0, '0, 1'b0, 1'b1);
    #3;
    chk("rstmid_pre_valid", int'(gnt_if.grant_valid), 1);
    chk("rstmid_pre_cnt1", cnt_of(1), 1);
    tick();
    chk("rstmid_valid", int'(gnt_if.grant_valid), 0);
    chk("rstmid_id", int'(gnt_if.grant_id), 0);
    chk("rstmid_cnt", int'(pending_cnt), 0);
    chk("rstmid_busy", int'(busy), 0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      logic [NP-1:0] r;
      logic [NP-1:0] c;
      for (int i = 0; i < NP; i++) begin
        r[i] = ($urandom_range(0, 2) == 0);
        c[i] = ($urandom_range(0, 40) == 0);
      end
      drive(r, c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 250) == 0));
      tick();
    end
    drive('0, '0, 1'b1, 1'b0);
    tick();
    @(negedge CLK);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arb_rr_sched.md
Name: arb_rr_sched

Overview:
- Round-robin packet scheduler in the encdec8b10b path; sits directly upstream of the 8b10b encoder.
- Holds one saturating pending-packet counter per source port. Each counter is incremented, decremented and cleared with the same en/dec/clear semantics as the team's counter block.
- Picks one port with pending work and presents its id to the encoder on a valid/ready handshake.
- Decrements that port's count on acceptance.

Parameters:
NPORTS, 4, number of requesting source ports (2..16)
NBITS, 4, width of each pending counter; max count 2**NBITS-1
IDW, $clog2(NPORTS), width of grant_id

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous active-high reset
req_en  in  NPORTS  bit i pulse = one packet enqueued on port i this cycle
clear  in  NPORTS  bit i = flush port i's pending count and overflow flag
grant_valid  out  1  grant_id is valid
grant_id  out  IDW  port being granted
grant_ready  in  1  encoder accepts the grant this cycle
pending_cnt  out  NPORTS*NBITS  per-port counts; port i at bits [i*NBITS +: NBITS]
ovf  out  NPORTS  sticky: increment on port i was dropped at saturation
busy  out  1  grant_valid or any pending_cnt != 0

Behaviour:
- Reset:
  - Sampled only on a CLK edge where RST=1.
  - All counts=0, ovf=0, grant_valid=0, grant_id=0, rr pointer=0, FSM=IDLE.
  - Reset mid-grant drops the grant with no decrement.
- Counter update per port i, evaluated in priority order:
  - clear[i] → count=0, ovf[i]=0.
  - Otherwise inc (req_en[i]) and dec (accepted grant on port i) in the same cycle → count unchanged.
  - Otherwise inc only → count+1. If count==2**NBITS-1, count holds and ovf[i] sets.
  - Otherwise dec only → count-1.
  - Otherwise hold.
  - Dec never occurs at count 0: a grant is issued only for count>0, and clear cancels the grant (see below).
- Handshake "accept" = grant_valid && grant_ready on a CLK edge.
- FSM states IDLE and GRANT:
  - IDLE, any count>0:
    - Select the first port with count>0 searching from rr pointer upward, wrapping NPORTS-1 → 0.
    - Next cycle: grant_valid=1, grant_id=selected port, state=GRANT.
  - IDLE, all counts zero: stay in IDLE, grant_valid=0.
  - GRANT:
    - grant_valid and grant_id stay stable until accept.
    - New req_en never changes grant_id.
  - GRANT on accept:
    - Decrement the granted port.
    - rr pointer = (grant_id+1) mod NPORTS.
    - Next cycle grant_valid=0, state=IDLE (one-cycle bubble).
  - GRANT with clear[grant_id]=1 on the same edge as, or before, accept:
    - Grant is withdrawn: next cycle grant_valid=0, IDLE.
    - No decrement, pointer unchanged.
- Latency: req_en at edge t → count visible after t; grant_valid=1 after edge t+1 (2 cycles from request to grant).
- Counts saturate and never wrap. The rr pointer wraps modulo NPORTS, including non-power-of-2 NPORTS.

Optional Feature:
- Macro ARB_BACK2BACK_EN.
- Defined:
  - On accept, the FSM re-evaluates with the post-accept counts and advanced pointer.
  - If any count would be >0, stay in GRANT with the new grant_id on the next cycle. No bubble; sustained one grant per cycle.
- Undefined:
  - Mandatory one-cycle IDLE bubble after every accept, as in Behaviour.
  - Maximum throughput is one grant per 2 cycles.

Test Plan:
- Reset and counting:
  - Stimulus: RST=1 for 2 cycles, then release; then req_en=4'b0001 for 3 cycles.
  - Required: pending_cnt[0]=3; grant_valid=1 with grant_id=0 two cycles after the first req; busy=1.
- Round-robin fairness:
  - Stimulus: load ports 0, 1 and 3 with count 2 each; grant_ready held at 1.
  - Required, macro undefined: grant_id sequence 0,1,3,0,1,3, each grant separated by one grant_valid=0 cycle; all counts end at 0.
  - Required, ARB_BACK2BACK_EN defined: same id sequence with no gaps.
- Saturation and ovf:
  - Stimulus: NBITS=4, 17 req_en pulses on port 2.
  - Required: count=15, ovf[2]=1.
  - Then clear[2] → count=0, ovf[2]=0.
- Simultaneous inc and dec:
  - Stimulus: port 1 count=3, granted; grant_ready=1 and req_en[1]=1 on the same edge.
  - Required: count stays 3; rr pointer=2.
- Stall and clear:
  - Stimulus: grant on port 0 with grant_ready=0 for 5 cycles.
  - Required: grant_id stays 0 with grant_valid=1 throughout.
  - Then assert clear[0]: grant_valid=0 next cycle, no decrement of other ports, rr pointer unchanged.
- Reset mid-grant:
  - Stimulus: RST=1 while grant_valid=1 and counts nonzero.
  - Required: next cycle all outputs 0 and FSM in IDLE; the asynchronous-edge check confirms nothing changes before the CLK edge.
